// File: rtl/vip_pkg.sv
// Shared definitions for the 3x3 binary VIP stages: morphology modes, sync latency
// and the window types used by the line-buffer based neighbourhood operators.
package vip_pkg;

    localparam int MORPH_ERODE    = 0;
    localparam int MORPH_DILATE   = 1;
    localparam int SYNC_DLY       = 3;
    localparam int LINE_RAM_DEPTH = 1024;

    // One window column: top = line y-2, mid = line y-1, bot = current line.
    typedef struct packed {
        logic top;
        logic mid;
        logic bot;
    } morph_col_t;

    // Each row holds columns x-2 (MSB) .. x (LSB).
    typedef struct packed {
        logic [2:0] top;
        logic [2:0] mid;
        logic [2:0] bot;
    } morph_win_t;

    // Neutral value for out-of-frame taps: 1 leaves an AND unchanged, 0 an OR.
    function automatic logic morph_pad(input int mode);
        return (mode == MORPH_ERODE);
    endfunction

    function automatic logic morph_reduce(input morph_win_t win, input int mode);
        return (mode == MORPH_DILATE) ? |win : &win;
    endfunction

endpackage

// File: rtl/line_shift_ram_1bit.sv
// Two-line 1-bit shift RAM: taps0x/taps1x return the pixel one and two lines above,
// registered one clock after the write strobe. Column address restarts on every href low.
module line_shift_ram_1bit #(
    parameter int DEPTH = 640
) (
    input  logic clock,
    input  logic rst_n,
    input  logic clken,
    input  logic per_frame_href,
    input  logic shiftin,
    output logic taps0x,
    output logic taps1x
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] addr;
    logic          line0 [DEPTH];
    logic          line1 [DEPTH];

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            addr   <= '0;
            taps0x <= 1'b0;
            taps1x <= 1'b0;
        end else if (!per_frame_href) begin
            addr <= '0;
        end else if (clken) begin
            taps0x <= line0[addr];
            taps1x <= line1[addr];
            addr   <= (addr == AW'(DEPTH - 1)) ? '0 : addr + AW'(1);
        end
    end

    // NOTE: the storage array has no reset so it maps onto block RAM; readers must
    // not trust its contents until two lines have been written.
    always_ff @(posedge clock) begin
        if (per_frame_href && clken) begin
            line0[addr] <= shiftin;
            line1[addr] <= line0[addr];
        end
    end

endmodule

// File: rtl/binary_morph_3x3.sv
// 3x3 binary erosion (AND) / dilation (OR) on a line-buffered window; the output is the
// window centre, and vsync/href/clken are re-timed by SYNC_DLY clocks to match.
module binary_morph_3x3
    import vip_pkg::*;
#(
    parameter int IMG_W  = 640,
    parameter int MODE   = MORPH_ERODE,
    parameter int PAD_EN = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic per_frame_vsync,
    input  logic per_frame_href,
    input  logic per_frame_clken,
    input  logic per_img_bit,
    output logic post_frame_vsync,
    output logic post_frame_href,
    output logic post_frame_clken,
    output logic post_img_bit
);

    localparam logic PAD    = morph_pad(MODE);
    localparam logic PAD_ON = (PAD_EN != 0);

    logic [SYNC_DLY-1:0] vsync_dly;
    logic [SYNC_DLY-1:0] href_dly;
    logic [SYNC_DLY-1:0] clken_dly;
    logic                href_d1;
    logic                clken_d1;
    logic                clken_d2;

    logic                taps0x;
    logic                taps1x;
    logic                cur_d1;
    logic [10:0]         line_cnt;
    morph_col_t          col_new;
    morph_win_t          win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_dly <= '0;
            href_dly  <= '0;
            clken_dly <= '0;
        end else begin
            // NOTE: non-blocking so each stage takes the value its predecessor held before the edge.
            vsync_dly <= {vsync_dly[SYNC_DLY-2:0], per_frame_vsync};
            href_dly  <= {href_dly[SYNC_DLY-2:0], per_frame_href};
            clken_dly <= {clken_dly[SYNC_DLY-2:0], per_frame_clken};
        end
    end

    assign href_d1  = href_dly[0];
    assign clken_d1 = clken_dly[0];
    assign clken_d2 = clken_dly[1];

    assign post_frame_vsync = vsync_dly[SYNC_DLY-1];
    assign post_frame_href  = href_dly[SYNC_DLY-1];
    assign post_frame_clken = clken_dly[SYNC_DLY-1];

    line_shift_ram_1bit #(
        .DEPTH(IMG_W)
    ) u_line_ram (
        .clock          (clk),
        .rst_n          (rst_n),
        .clken          (per_frame_clken),
        .per_frame_href (per_frame_href),
        .shiftin        (per_img_bit),
        .taps0x         (taps0x),
        .taps1x         (taps1x)
    );

    // Current pixel is delayed one clock to line up with the registered RAM taps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_d1 <= 1'b0;
        end else if (per_frame_clken) begin
            cur_d1 <= per_img_bit;
        end
    end

    // Lines completed in this frame, saturating at 2 (enough to know both taps are real).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_cnt <= '0;
        end else if (!per_frame_vsync) begin
            line_cnt <= '0;
        end else if (href_d1 && !per_frame_href && (line_cnt < 11'd2)) begin
            line_cnt <= line_cnt + 11'd1;
        end
    end

    always_comb begin
        // NOTE: every field gets its default first, so no path leaves col_new latched.
        col_new.top = taps1x;
        col_new.mid = taps0x;
        col_new.bot = cur_d1;
        if (PAD_ON) begin
            if (line_cnt == 11'd0) begin
                col_new.top = PAD;
                col_new.mid = PAD;
            end else if (line_cnt == 11'd1) begin
                col_new.top = PAD;
            end
        end
    end

    // Loading pad during href low supplies the left-edge columns and flushes the
    // previous line's tail; without padding the stale tail is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win <= '0;
        end else if (PAD_ON && !href_d1) begin
            win <= {9{PAD}};
        end else if (clken_d1) begin
            win.top <= {win.top[1:0], col_new.top};
            win.mid <= {win.mid[1:0], col_new.mid};
            win.bot <= {win.bot[1:0], col_new.bot};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_img_bit <= 1'b0;
        end else if (clken_d2) begin
            post_img_bit <= morph_reduce(win, MODE);
        end
    end

endmodule
